// File: rtl/program_sequencer.sv
// program_sequencer
//   Program-counter sequencer with a bounded return stack and a
//   req/done four-phase handshake.
//
//   Parameters
//     D   program-counter width in bits
//     SD  return-stack depth in entries (>= 1)
//     CW  cycle-counter width in bits
//
//   Ports
//     clk          single clock, rising edge
//     reset        synchronous, active-high
//     req          run request (held high until done is seen)
//     start_addr   entry address, taken when req is accepted in IDLE
//     jump_en      taken jump/branch this cycle
//     call_en      subroutine call this cycle
//     ret_en       subroutine return this cycle
//     halt         current instruction is halt
//     target       jump/call destination
//     prog_ctr     current instruction address
//     running      high while in RUN
//     done         high while in DONE
//     stack_err    sticky return-stack overflow/underflow flag
//     cycle_count  RUN cycles executed for the current program (saturating)
module program_sequencer #(
    parameter int unsigned D  = 12,
    parameter int unsigned SD = 4,
    parameter int unsigned CW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req,
    input  logic [D-1:0]  start_addr,
    input  logic          jump_en,
    input  logic          call_en,
    input  logic          ret_en,
    input  logic          halt,
    input  logic [D-1:0]  target,
    output logic [D-1:0]  prog_ctr,
    output logic          running,
    output logic          done,
    output logic          stack_err,
    output logic [CW-1:0] cycle_count
);

    localparam int unsigned SPW = $clog2(SD + 1);
    localparam int unsigned IW  = (SD > 1) ? $clog2(SD) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t         state;
    logic [SPW-1:0] sp;
    logic [D-1:0]   stack [SD];

    logic           stack_empty;
    logic           stack_full;
    logic [IW-1:0]  push_idx;
    logic [IW-1:0]  top_idx;
    logic [D-1:0]   pc_next_seq;

    always_comb begin
        stack_empty = (sp == '0);
        stack_full  = (sp == SPW'(SD));
        // sp counts entries, so the next free slot is sp and the top is sp-1
        push_idx    = IW'(sp);
        top_idx     = IW'(sp - SPW'(1));
        pc_next_seq = prog_ctr + D'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            prog_ctr    <= '0;
            cycle_count <= '0;
            stack_err   <= 1'b0;
            sp          <= '0;
            running     <= 1'b0;
            done        <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req) begin
                        state       <= S_RUN;
                        running     <= 1'b1;
                        done        <= 1'b0;
                        prog_ctr    <= start_addr;
                        cycle_count <= '0;
                        sp          <= '0;
                        stack_err   <= 1'b0;
                    end
                end

                S_RUN: begin
                    if (cycle_count != '1) begin
                        cycle_count <= cycle_count + CW'(1);
                    end
                    // Fixed priority: halt > ret > call > jump > sequential.
                    // Error exits hold prog_ctr at the faulting instruction.
                    if (halt) begin
                        state   <= S_DONE;
                        running <= 1'b0;
                        done    <= 1'b1;
                    end else if (ret_en) begin
                        if (stack_empty) begin
                            stack_err <= 1'b1;
                            state     <= S_DONE;
                            running   <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            prog_ctr <= stack[top_idx];
                            sp       <= sp - SPW'(1);
                        end
                    end else if (call_en) begin
                        if (stack_full) begin
                            stack_err <= 1'b1;
                            state     <= S_DONE;
                            running   <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            stack[push_idx] <= pc_next_seq;
                            sp              <= sp + SPW'(1);
                            prog_ctr        <= target;
                        end
                    end else if (jump_en) begin
                        prog_ctr <= target;
                    end else begin
                        prog_ctr <= pc_next_seq;
                    end
                end

                S_DONE: begin
                    if (!req) begin
                        state <= S_IDLE;
                        done  <= 1'b0;
                    end
                end

                default: begin
                    state   <= S_IDLE;
                    running <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule
